video_sync_decoder: RTL and testbench

Receive-side counterpart of the core's video output stage: consumes a pixel-clock-enabled HS/VS/DE/RGB stream, recovers pixel coordinates, and measures frame geometry. Feeds frame grabbers, OSD overlays and test benches that must check the emitted raster without knowledge of the PPU counters. Sits on the system clock domain, after the video output stage and before any capture or compare logic.

---
 rtl/video_sync_decoder.sv | 173 +++++++++++++++++
 tb/tb_video_sync_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_sync_decoder.sv
// Receive-side raster decoder: recovers pixel coordinates from an HS/VS/DE/RGB
// stream and measures frame geometry, asserting locked once the geometry repeats.
module video_sync_decoder #(
    parameter int CNT_W       = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic             hs,
    input  logic             vs,
    input  logic             de,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [14:0]      pix_rgb,
    output logic             frame_start,
    output logic [CNT_W-1:0] active_w,
    output logic [CNT_W-1:0] active_h,
    output logic [CNT_W-1:0] total_h,
    output logic [CNT_W-1:0] total_v,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               STB_W   = $clog2(LOCK_FRAMES + 1);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(LOCK_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [14:0] pack_rgb(input logic [7:0] cr, input logic [7:0] cg,
                                             input logic [7:0] cb);
        return {cb[7:3], cg[7:3], cr[7:3]};
    endfunction

    logic        vld_p0;
    logic        seen_p0, seen_prev_p0;
    logic        hs_p0, hs_prev_p0;
    logic        vs_p0, vs_prev_p0;
    logic        de_p0;
    logic [14:0] rgb_p0;

    logic [CNT_W-1:0] hcnt, xcnt, ycnt, lcnt, line_total, line_de;
    logic [STB_W-1:0] stable;

    logic             hs_rise, vs_rise, pix_stb, line_had_de, geo_match, wdog;
    logic [CNT_W-1:0] hcnt_nxt, xcnt_nxt, ycnt_nxt, lcnt_nxt, line_total_nxt, line_de_nxt;
    logic [CNT_W-1:0] pix_x_nxt;
    logic [STB_W-1:0] stable_nxt;

    // Stage p0: input sample plus the previous sample for edge detection.
    // seen_prev_p0 suppresses edges until a genuine previous sample exists.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0       <= 1'b0;
            seen_p0      <= 1'b0;
            seen_prev_p0 <= 1'b0;
            hs_p0        <= 1'b0;
            hs_prev_p0   <= 1'b0;
            vs_p0        <= 1'b0;
            vs_prev_p0   <= 1'b0;
            de_p0        <= 1'b0;
            rgb_p0       <= '0;
        end else begin
            vld_p0 <= ce_pix;
            if (ce_pix) begin
                seen_p0      <= 1'b1;
                seen_prev_p0 <= seen_p0;
                hs_p0        <= hs;
                hs_prev_p0   <= hs_p0;
                vs_p0        <= vs;
                vs_prev_p0   <= vs_p0;
                de_p0        <= de;
                rgb_p0       <= pack_rgb(r, g, b);
            end
        end
    end

    assign hs_rise = vld_p0 & seen_prev_p0 & hs_p0 & ~hs_prev_p0;
    assign vs_rise = vld_p0 & seen_prev_p0 & vs_p0 & ~vs_prev_p0;
    assign pix_stb = vld_p0 & de_p0;
    assign locked  = (stable == STB_MAX);

    // HS processing resolves first so a coincident VS sees the closing line.
    always_comb begin
        hcnt_nxt       = hcnt;
        xcnt_nxt       = xcnt;
        ycnt_nxt       = ycnt;
        lcnt_nxt       = lcnt;
        line_total_nxt = line_total;
        line_de_nxt    = line_de;
        line_had_de    = (xcnt != '0);
        pix_x_nxt      = hs_rise ? '0 : xcnt;
        if (vld_p0) begin
            if (hs_rise) begin
                hcnt_nxt       = '0;
                line_total_nxt = sat_inc(hcnt);
                if (line_had_de) begin
                    line_de_nxt = xcnt;
                    ycnt_nxt    = sat_inc(ycnt);
                end
                lcnt_nxt = sat_inc(lcnt);
                xcnt_nxt = '0;
            end else begin
                hcnt_nxt = sat_inc(hcnt);
            end
            if (de_p0) begin
                xcnt_nxt = sat_inc(xcnt_nxt);
            end
        end
        geo_match = (line_de_nxt == active_w) && (ycnt_nxt == active_h) &&
                    (line_total_nxt == total_h) && (lcnt_nxt == total_v);
        wdog = vld_p0 && ((hcnt_nxt == CNT_MAX) || (lcnt_nxt == CNT_MAX));
        stable_nxt = stable;
        if (vs_rise) begin
            stable_nxt = geo_match ? ((stable == STB_MAX) ? stable : stable + 1'b1) : '0;
        end
        if (wdog) begin
            stable_nxt = '0;
        end
    end

    // Stage p1: counters, pixel strobe and latched geometry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt        <= '0;
            xcnt        <= '0;
            ycnt        <= '0;
            lcnt        <= '0;
            line_total  <= '0;
            line_de     <= '0;
            stable      <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            active_w    <= '0;
            active_h    <= '0;
            total_h     <= '0;
            total_v     <= '0;
        end else begin
            pix_valid   <= pix_stb;
            frame_start <= vs_rise;
            if (vld_p0) begin
                hcnt       <= hcnt_nxt;
                xcnt       <= xcnt_nxt;
                ycnt       <= vs_rise ? '0 : ycnt_nxt;
                lcnt       <= vs_rise ? '0 : lcnt_nxt;
                line_total <= line_total_nxt;
                line_de    <= line_de_nxt;
                stable     <= stable_nxt;
            end
            if (pix_stb) begin
                pix_x   <= pix_x_nxt;
                pix_y   <= ycnt_nxt;
                pix_rgb <= rgb_p0;
            end
            if (vs_rise) begin
                active_w <= line_de_nxt;
                active_h <= ycnt_nxt;
                total_h  <= line_total_nxt;
                total_v  <= lcnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder on a reduced 48x30 raster
// (24x20 active, HS on samples 30-34, VS on lines 23-25).
module tb_video_sync_decoder;

    localparam int H_TOT = 48, H_ACT = 24, H_HS0 = 30, H_HS1 = 34;
    localparam int V_ACT = 20, V_VS0 = 23, V_VS1 = 25, V_NOM = 30;

    logic       clk = 1'b0, reset_n = 1'b0, ce_pix = 1'b0;
    logic       hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
    logic       pix_valid, frame_start, locked;
    logic [9:0] pix_x, pix_y, active_w, active_h, total_h, total_v;
    logic [14:0] pix_rgb;

    int checks = 0, errors = 0, ce_gap = 1;
    int stb_total = 0, pv_long = 0, fs_cnt = 0, fs_long = 0;
    logic pv_prev = 1'b0, fs_prev = 1'b0;
    int cap_idx[3] = '{-1, -1, -1};
    logic [9:0]  cap_x[3] = '{default: '0};
    logic [9:0]  cap_y[3] = '{default: '0};
    logic [14:0] cap_rgb[3] = '{default: '0};
    logic [9:0] snap_w = '0, snap_h = '0, snap_th = '0, snap_tv = '0;
    logic snap_lk = 1'b0;

    video_sync_decoder #(.CNT_W(10), .LOCK_FRAMES(2)) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
        .hs(hs), .vs(vs), .de(de), .r(r), .g(g), .b(b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .active_w(active_w), .active_h(active_h),
        .total_h(total_h), .total_v(total_v), .locked(locked)
    );

    always #5 clk = ~clk;

    // Passive monitor: strobe counting, pulse widths and frame snapshots.
    always @(negedge clk) begin
        if (pix_valid) begin
            for (int i = 0; i < 3; i++) begin
                if (stb_total == cap_idx[i]) begin
                    cap_x[i]   <= pix_x;
                    cap_y[i]   <= pix_y;
                    cap_rgb[i] <= pix_rgb;
                end
            end
            stb_total <= stb_total + 1;
        end
        if (pix_valid && pv_prev) pv_long <= pv_long + 1;
        pv_prev <= pix_valid;
        if (frame_start) begin
            fs_cnt  <= fs_cnt + 1;
            snap_w  <= active_w;
            snap_h  <= active_h;
            snap_th <= total_h;
            snap_tv <= total_v;
            snap_lk <= locked;
        end
        if (frame_start && fs_prev) fs_long <= fs_long + 1;
        fs_prev <= frame_start;
    end

    task automatic drive_sample(input logic s_hs, input logic s_vs, input logic s_de,
                                input logic [7:0] s_r, input logic [7:0] s_g, input logic [7:0] s_b);
        hs = s_hs; vs = s_vs; de = s_de; r = s_r; g = s_g; b = s_b;
        ce_pix = 1'b1;
        @(posedge clk); #1;
        ce_pix = 1'b0;
        repeat (ce_gap) begin @(posedge clk); #1; end
    endtask

    task automatic drive_line(input int ln, input int s0, input int s1, input int vs_start);
        for (int s = s0; s <= s1; s++) begin
            drive_sample(s >= H_HS0 && s <= H_HS1,
                         (ln >= V_VS0 && ln <= V_VS1) && !(ln == V_VS0 && s < vs_start),
                         ln < V_ACT && s < H_ACT, 8'(s), 8'(ln), 8'hF8);
        end
    endtask

    task automatic drive_frame(input int nlines, input int vs_start);
        for (int ln = 0; ln < nlines; ln++) drive_line(ln, 0, H_TOT - 1, vs_start);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({pix_valid, frame_start, locked} !== 3'b000) begin errors++;
            $display("FAIL reset_strobes: got %b expected 000", {pix_valid, frame_start, locked}); end
        checks++; if ({active_w, active_h, total_h, total_v} !== 40'd0) begin errors++;
            $display("FAIL reset_geometry: got %h expected 0", {active_w, active_h, total_h, total_v}); end
        checks++; if ({pix_x, pix_y, pix_rgb} !== 35'd0) begin errors++;
            $display("FAIL reset_pixel: got %h expected 0", {pix_x, pix_y, pix_rgb}); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        drive_sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        drive_sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (fs_cnt !== 0) begin errors++;
            $display("FAIL reset_no_edge: got %0d frame_starts expected 0", fs_cnt); end
    endtask

    task automatic test_nominal();
        drive_frame(V_NOM, 0);
        checks++; if (fs_cnt !== 1) begin errors++;
            $display("FAIL nom_fs1: got %0d expected 1", fs_cnt); end
        checks++; if ({snap_w, snap_h, snap_tv} !== {10'd24, 10'd20, 10'd23}) begin errors++;
            $display("FAIL nom_partial: got w%0d h%0d tv%0d expected w24 h20 tv23", snap_w, snap_h, snap_tv); end
        checks++; if (snap_lk !== 1'b0) begin errors++;
            $display("FAIL nom_lk1: got %b expected 0", snap_lk); end
        drive_frame(V_NOM, 0);
        checks++; if (snap_tv !== 10'd30 || snap_lk !== 1'b0) begin errors++;
            $display("FAIL nom_vs2: got tv%0d lk%b expected tv30 lk0", snap_tv, snap_lk); end
        drive_frame(V_NOM, 0);
        checks++; if (snap_lk !== 1'b0) begin errors++;
            $display("FAIL nom_lk3: got %b expected 0", snap_lk); end
        drive_frame(V_NOM, 0);
        checks++; if (snap_lk !== 1'b1) begin errors++;
            $display("FAIL nom_lk4: got %b expected 1", snap_lk); end
        checks++; if ({snap_w, snap_h, snap_th, snap_tv} !== {10'd24, 10'd20, 10'd48, 10'd30}) begin errors++;
            $display("FAIL nom_geom: got w%0d h%0d th%0d tv%0d expected w24 h20 th48 tv30",
                     snap_w, snap_h, snap_th, snap_tv); end
        checks++; if (fs_long !== 0 || fs_cnt !== 4) begin errors++;
            $display("FAIL nom_fs_pulse: got long%0d cnt%0d expected long0 cnt4", fs_long, fs_cnt); end
    endtask

    task automatic test_pixel();
        int base;
        base = stb_total;
        cap_idx[0] = base;
        cap_idx[1] = base + 17 * H_ACT + 20;
        cap_idx[2] = base + V_ACT * H_ACT - 1;
        ce_gap = 3;
        drive_frame(V_NOM, 0);
        ce_gap = 1;
        checks++; if (stb_total - base !== 480) begin errors++;
            $display("FAIL pix_count: got %0d expected 480", stb_total - base); end
        checks++; if ({cap_x[0], cap_y[0], cap_rgb[0]} !== {10'd0, 10'd0, 15'h7C00}) begin errors++;
            $display("FAIL pix_first: got x%0d y%0d rgb%h expected x0 y0 rgb7c00", cap_x[0], cap_y[0], cap_rgb[0]); end
        checks++; if ({cap_x[1], cap_y[1], cap_rgb[1]} !== {10'd20, 10'd17, 15'h7C42}) begin errors++;
            $display("FAIL pix_17_20: got x%0d y%0d rgb%h expected x20 y17 rgb7c42", cap_x[1], cap_y[1], cap_rgb[1]); end
        checks++; if ({cap_x[2], cap_y[2]} !== {10'd23, 10'd19}) begin errors++;
            $display("FAIL pix_last: got x%0d y%0d expected x23 y19", cap_x[2], cap_y[2]); end
        checks++; if (pv_long !== 0) begin errors++;
            $display("FAIL pix_pulse: got %0d long strobes expected 0", pv_long); end
        checks++; if (snap_lk !== 1'b1) begin errors++;
            $display("FAIL pix_locked: got %b expected 1", snap_lk); end
    endtask

    task automatic test_geometry_change();
        drive_frame(29, 0);
        checks++; if (snap_tv !== 10'd30 || snap_lk !== 1'b1) begin errors++;
            $display("FAIL geo_before: got tv%0d lk%b expected tv30 lk1", snap_tv, snap_lk); end
        drive_frame(29, 0);
        checks++; if (snap_tv !== 10'd29 || snap_lk !== 1'b0) begin errors++;
            $display("FAIL geo_change: got tv%0d lk%b expected tv29 lk0", snap_tv, snap_lk); end
        drive_frame(29, 0);
        checks++; if (snap_lk !== 1'b0) begin errors++;
            $display("FAIL geo_one_match: got %b expected 0", snap_lk); end
        drive_frame(29, 0);
        checks++; if (snap_tv !== 10'd29 || snap_lk !== 1'b1) begin errors++;
            $display("FAIL geo_relock: got tv%0d lk%b expected tv29 lk1", snap_tv, snap_lk); end
    endtask

    task automatic test_sync_loss();
        int base;
        base = fs_cnt;
        repeat (1000) drive_sample(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        checks++; if (locked !== 1'b1) begin errors++;
            $display("FAIL loss_early: got %b expected 1", locked); end
        repeat (10) drive_sample(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        checks++; if (locked !== 1'b0) begin errors++;
            $display("FAIL loss_wdog: got %b expected 0", locked); end
        checks++; if (fs_cnt !== base) begin errors++;
            $display("FAIL loss_quiet: got %0d frame_starts expected %0d", fs_cnt, base); end
        drive_frame(29, 0);
        checks++; if (fs_cnt !== base + 1 || snap_lk !== 1'b0 || snap_th !== 10'd48) begin errors++;
            $display("FAIL loss_resume: got cnt%0d lk%b th%0d expected cnt%0d lk0 th48",
                     fs_cnt, snap_lk, snap_th, base + 1); end
        drive_frame(29, 0);
        checks++; if (snap_lk !== 1'b1) begin errors++;
            $display("FAIL loss_relock: got %b expected 1", snap_lk); end
    endtask

    task automatic test_coincident();
        drive_frame(29, H_HS0);
        checks++; if (snap_tv !== 10'd30 || snap_h !== 10'd20) begin errors++;
            $display("FAIL coin_tv: got tv%0d h%0d expected tv30 h20", snap_tv, snap_h); end
        cap_idx[0] = stb_total;
        drive_frame(29, 0);
        checks++; if ({cap_x[0], cap_y[0]} !== {10'd0, 10'd0}) begin errors++;
            $display("FAIL coin_first_pix: got x%0d y%0d expected x0 y0", cap_x[0], cap_y[0]); end
        checks++; if (snap_tv !== 10'd28) begin errors++;
            $display("FAIL coin_next_tv: got %0d expected 28", snap_tv); end
    endtask

    task automatic test_mid_reset();
        int base;
        for (int ln = 0; ln < 10; ln++) drive_line(ln, 0, H_TOT - 1, 0);
        drive_line(10, 0, 5, 0);
        reset_n = 1'b0;
        #1;
        checks++; if ({pix_valid, frame_start, locked, pix_x, pix_y, pix_rgb} !== 38'd0) begin errors++;
            $display("FAIL mrst_pixel: got %h expected 0", {pix_valid, frame_start, locked, pix_x, pix_y, pix_rgb}); end
        checks++; if ({active_w, active_h, total_h, total_v} !== 40'd0) begin errors++;
            $display("FAIL mrst_geometry: got %h expected 0", {active_w, active_h, total_h, total_v}); end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        base = fs_cnt;
        drive_line(10, 6, H_TOT - 1, 0);
        for (int ln = 11; ln < 29; ln++) drive_line(ln, 0, H_TOT - 1, 0);
        checks++; if (fs_cnt !== base + 1 || snap_h !== 10'd10 || snap_tv !== 10'd13 || snap_lk !== 1'b0) begin errors++;
            $display("FAIL mrst_vs1: got cnt%0d h%0d tv%0d lk%b expected cnt%0d h10 tv13 lk0",
                     fs_cnt, snap_h, snap_tv, snap_lk, base + 1); end
        drive_frame(29, 0);
        checks++; if (snap_tv !== 10'd29 || snap_lk !== 1'b0) begin errors++;
            $display("FAIL mrst_vs2: got tv%0d lk%b expected tv29 lk0", snap_tv, snap_lk); end
        drive_frame(29, 0);
        checks++; if (snap_lk !== 1'b0) begin errors++;
            $display("FAIL mrst_vs3: got %b expected 0", snap_lk); end
        drive_frame(29, 0);
        checks++; if (snap_lk !== 1'b1 || snap_h !== 10'd20) begin errors++;
            $display("FAIL mrst_vs4: got lk%b h%0d expected lk1 h20", snap_lk, snap_h); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_pixel();
        test_geometry_change();
        test_sync_loss();
        test_coincident();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
